// File: rtl/mux_synchro.sv
// Recirculation-mux synchronizer: only the enable qualifier crosses into clk2; data is captured by a hold register.
// Optional build macro MUX_SYNCHRO_EDGE_LOAD_EN selects one load per enable assertion instead of level-sensitive tracking.
module mux_synchro #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk2,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  output logic [WIDTH-1:0] synchro_out
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("mux_synchro: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync;
  logic                   en_sync;
  logic                   load;
  logic [WIDTH-1:0]       data_q;

  // Enable synchronizer chain; sync[0] is the only flop that sees the asynchronous input
  always_ff @(posedge clk2) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], enable};
    end
  end

  assign en_sync = sync[SYNC_STAGES-1];

`ifdef MUX_SYNCHRO_EDGE_LOAD_EN
  logic en_d;

  always_ff @(posedge clk2) begin
    if (reset) begin
      en_d <= 1'b0;
    end else begin
      en_d <= en_sync;
    end
  end

  assign load = en_sync & ~en_d;
`else
  assign load = en_sync;
`endif

  // Hold register: data_in is only sampled once the synchronized enable says it is stable
  always_ff @(posedge clk2) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (load) begin
      data_q <= data_in;
    end
  end

  assign synchro_out = data_q;

endmodule

// File: tb/tb_mux_synchro.sv
// Directed bench for mux_synchro (WIDTH=4, SYNC_STAGES=2, RESET_VAL=0); expectations follow the build macro.
module tb_mux_synchro;

  logic       clk2 = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       enable;
  logic [3:0] synchro_out;

  int checks   = 0;
  int failures = 0;

`ifdef MUX_SYNCHRO_EDGE_LOAD_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  mux_synchro #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .RESET_VAL   (4'h0)
  ) dut (
    .clk2        (clk2),
    .reset       (reset),
    .data_in     (data_in),
    .enable      (enable),
    .synchro_out (synchro_out)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_track;
    logic [3:0] exp_hold;
    logic [3:0] tog;

    exp_track = EDGE_MODE ? 4'hA : 4'h5;
    exp_hold  = EDGE_MODE ? 4'hA : 4'h6;

    // reset held 3 edges with enable high: output stays at reset value
    reset   = 1'b1;
    enable  = 1'b1;
    data_in = 4'hA;
    tick(); chk("reset_e1", synchro_out, 4'h0);
    tick(); chk("reset_e2", synchro_out, 4'h0);
    tick(); chk("reset_e3", synchro_out, 4'h0);

    // release: chain refills, load lands on the third edge
    reset = 1'b0;
    tick(); chk("post_rst_e1", synchro_out, 4'h0);
    tick(); chk("post_rst_e2", synchro_out, 4'h0);
    tick(); chk("post_rst_load", synchro_out, 4'hA);

    // tracking while en_sync remains high
    data_in = 4'h5;
    tick(); chk("track", synchro_out, exp_track);

    // enable drops; two more loads occur while the chain drains
    enable = 1'b0;
    tick(); chk("drain_e1", synchro_out, exp_track);
    data_in = 4'h6;
    tick(); chk("drain_last_load", synchro_out, exp_hold);

    // data toggles with en_sync low: held value must not move
    tog = 4'h3;
    for (int i = 0; i < 5; i++) begin
      data_in = tog;
      tick(); chk("hold", synchro_out, exp_hold);
      tog = ~tog;
    end

    // re-enable with new data: update exactly SYNC_STAGES+1 edges later
    data_in = 4'h9;
    enable  = 1'b1;
    tick(); chk("reen_e1", synchro_out, exp_hold);
    tick(); chk("reen_e2", synchro_out, exp_hold);
    tick(); chk("reen_load", synchro_out, 4'h9);

    // single-cycle reset while en_sync is high overrides the coincident load
    data_in = 4'hF;
    reset   = 1'b1;
    tick(); chk("mid_reset", synchro_out, 4'h0);
    reset = 1'b0;
    tick(); chk("mid_rst_e1", synchro_out, 4'h0);
    tick(); chk("mid_rst_e2", synchro_out, 4'h0);
    tick(); chk("mid_rst_reload", synchro_out, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
